mips_muldiv_unit: RTL

Iterative, parametrised HI/LO multiply/divide unit for the MIPS core, replacing single-cycle HI/LO arithmetic. It executes MULT, MULTU, DIV and DIVU over WIDTH+1 clock edges. It owns the HI and LO registers, including MTHI/MTLO writes, and asserts `busy` so the core stalls on MFHI/MFLO and on any new HI/LO operation.

---
 rtl/mips_muldiv_unit.sv | 109 ++++++++++
 1 files changed

// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit: iterative HI/LO multiply/divide unit (WIDTH+1 edges per op).
// MIPS_MULDIV_DIV_EN builds the restoring divider; without it DIV/DIVU only time out.
module mips_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clock_enable,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [2*WIDTH-1:0] r_acc, w_step, w_mstep, w_prod;
  logic [WIDTH-1:0] r_opnd, r_hi, r_lo, w_hi, w_lo, w_a_mag, w_b_mag;
  logic [WIDTH:0] w_madd;
  logic r_div, r_neg_q, r_done, w_accept, w_sa, w_sb;
`ifdef MIPS_MULDIV_DIV_EN
  logic r_neg_r, r_dz;
  logic [WIDTH:0] w_shift, w_diff;
  logic [2*WIDTH-1:0] w_dstep;
`endif
  assign w_accept = start & (r_state == S_IDLE);
  assign w_sa = ~op[0] & op_a[WIDTH-1];
  assign w_sb = ~op[0] & op_b[WIDTH-1];
  assign w_a_mag = w_sa ? -op_a : op_a;
  assign w_b_mag = w_sb ? -op_b : op_b;
  // Multiply: acc = {partial product, multiplier}; opnd holds the multiplicand.
  assign w_madd = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mstep = {w_madd, r_acc[WIDTH-1:1]};
  assign w_prod = r_neg_q ? -r_acc : r_acc;
`ifdef MIPS_MULDIV_DIV_EN
  // Divide: acc = {remainder, dividend/quotient}; opnd holds the divisor.
  assign w_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_diff = w_shift - {1'b0, r_opnd};
  assign w_dstep = w_diff[WIDTH] ? {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                 : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
  assign w_step = r_div ? w_dstep : w_mstep;
  // Divide by zero leaves |a| in the remainder, so re-signing it restores op_a.
  assign w_hi = r_div ? (r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH])
                      : w_prod[2*WIDTH-1:WIDTH];
  assign w_lo = r_div ? (r_dz ? '1 : r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0])
                      : w_prod[WIDTH-1:0];
`else
  assign w_step = w_mstep;
  assign w_hi = r_div ? r_hi : w_prod[2*WIDTH-1:WIDTH];
  assign w_lo = r_div ? r_lo : w_prod[WIDTH-1:0];
`endif
  always_comb begin
    w_next = r_state;
    w_next = (r_state == S_IDLE) ? (w_accept ? S_RUN : S_IDLE) :
             (r_state == S_RUN)  ? ((r_cnt == CW'(WIDTH - 1)) ? S_FINISH : S_RUN) : S_IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_opnd  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_done  <= 1'b0;
`ifdef MIPS_MULDIV_DIV_EN
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
`endif
    end else if (clock_enable) begin
      r_state <= w_next;
      r_done  <= (r_state == S_FINISH);
      if (w_accept) begin
        r_div   <= op[1];
        r_neg_q <= w_sa ^ w_sb;
        r_cnt   <= '0;
        r_opnd  <= op[1] ? w_b_mag : w_a_mag;
        r_acc   <= {{WIDTH{1'b0}}, op[1] ? w_a_mag : w_b_mag};
`ifdef MIPS_MULDIV_DIV_EN
        r_neg_r <= w_sa;
        r_dz    <= (op_b == '0);
`endif
      end else if (r_state == S_RUN) begin
        r_cnt <= r_cnt + CW'(1);
        r_acc <= w_step;
      end
      if (r_state == S_FINISH) begin
        r_hi <= w_hi;
        r_lo <= w_lo;
      end else if (r_state == S_IDLE && !start) begin
        if (mthi) r_hi <= op_a;
        if (mtlo) r_lo <= op_a;
      end
    end
  end
  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign hi = r_hi;
  assign lo = r_lo;
endmodule
